// File: rtl/sdp_ram.sv
// Simple dual-port RAM with a registered read port, so synthesis can map
// the pixel buffer onto block RAM.
module sdp_ram #(
    parameter int unsigned p_width  = 24,
    parameter int unsigned p_addr_w = 5
) (
    input  logic                i_clk,
    input  logic                i_wr_en,
    input  logic [p_addr_w-1:0] i_wr_addr,
    input  logic [p_width-1:0]  i_wr_data,
    input  logic                i_rd_en,
    input  logic [p_addr_w-1:0] i_rd_addr,
    output logic [p_width-1:0]  o_rd_data
);

    localparam int unsigned c_depth = 1 << p_addr_w;

    logic [p_width-1:0] mem_q [c_depth];
    logic [p_width-1:0] rd_data_q;

    // No reset on the array or read register: block RAM cannot be cleared.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            rd_data_q <= mem_q[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/pixel_align_fifo.sv
// Pixel re-alignment buffer: absorbs variable upstream latency and releases
// one word per display data-enable, flagging underflow/overflow per frame.
module pixel_align_fifo #(
    parameter int unsigned p_width        = 24,
    parameter int unsigned p_depth_log2   = 5,
    parameter int unsigned p_afull_margin = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_frame_start,
    input  logic                    i_valid,
    input  logic [p_width-1:0]      i_data,
    output logic                    o_ready,
    input  logic                    i_de,
    output logic                    o_de,
    output logic [p_width-1:0]      o_data,
    output logic [p_depth_log2:0]   o_level,
    output logic                    o_underflow,
    output logic                    o_overflow
);

    localparam int unsigned c_depth    = 1 << p_depth_log2;
    localparam int unsigned c_rmax_i   = c_depth - p_afull_margin;
    localparam logic [p_depth_log2:0]   c_full    = c_depth[p_depth_log2:0];
    localparam logic [p_depth_log2:0]   c_rmax    = c_rmax_i[p_depth_log2:0];
    localparam logic [p_depth_log2-1:0] c_ptr_one = 1;
    localparam logic [p_depth_log2:0]   c_lvl_one = 1;

    logic [p_depth_log2-1:0] wr_ptr_q, wr_ptr_d;
    logic [p_depth_log2-1:0] rd_ptr_q, rd_ptr_d;
    logic [p_depth_log2:0]   level_q, level_d;
    logic                    underflow_q, underflow_d;
    logic                    overflow_q, overflow_d;
    logic                    de_q, de_d;
    logic                    rd_hit_q, rd_hit_d;
    logic [p_width-1:0]      hold_q, hold_d;

    logic                    wr_ok;
    logic                    rd_ok;
    logic [p_width-1:0]      ram_rdata;

    // Fullness/emptiness are judged on the registered level only, so a
    // same-cycle read never frees a slot and there is no write bypass.
    always_comb begin
        wr_ok       = i_valid && (level_q < c_full);
        rd_ok       = i_de && (level_q != '0);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        de_d        = i_de;
        rd_hit_d    = rd_ok;
        hold_d      = o_data;

        if (i_frame_start) begin
            wr_ok       = 1'b0;
            rd_ok       = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            underflow_d = 1'b0;
            overflow_d  = 1'b0;
            de_d        = 1'b0;
            rd_hit_d    = 1'b0;
            hold_d      = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + c_ptr_one;
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + c_ptr_one;
            end
            if (i_valid && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (i_de && !rd_ok) begin
                underflow_d = 1'b1;
                hold_d      = '0;
            end
            if (wr_ok && !rd_ok) begin
                level_d = level_q + c_lvl_one;
            end else if (rd_ok && !wr_ok) begin
                level_d = level_q - c_lvl_one;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            de_q        <= 1'b0;
            rd_hit_q    <= 1'b0;
            hold_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            de_q        <= de_d;
            rd_hit_q    <= rd_hit_d;
            hold_q      <= hold_d;
        end
    end

    sdp_ram #(
        .p_width  (p_width),
        .p_addr_w (p_depth_log2)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (wr_ok && !i_rst),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data (i_data),
        .i_rd_en   (rd_ok && !i_rst),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (ram_rdata)
    );

    // RAM output is only trusted the cycle after a successful pop; otherwise
    // the held value (or zero after underflow/flush/reset) is presented.
    assign o_data      = rd_hit_q ? ram_rdata : hold_q;
    assign o_de        = de_q;
    assign o_level     = level_q;
    assign o_underflow = underflow_q;
    assign o_overflow  = overflow_q;
    assign o_ready     = (level_q <= c_rmax);

endmodule

// File: tb/tb_pixel_align_fifo.sv
// Scoreboard bench for pixel_align_fifo: a queue model predicts each popped
// word and all status outputs, compared one cycle after stimulus.
module tb_pixel_align_fifo;

    localparam int W      = 24;
    localparam int AW     = 5;
    localparam int DEPTH  = 32;
    localparam int MARGIN = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_frame_start;
    logic          i_valid;
    logic [W-1:0]  i_data;
    logic          o_ready;
    logic          i_de;
    logic          o_de;
    logic [W-1:0]  o_data;
    logic [AW:0]   o_level;
    logic          o_underflow;
    logic          o_overflow;

    always #5 i_clk = ~i_clk;

    pixel_align_fifo #(
        .p_width        (W),
        .p_depth_log2   (AW),
        .p_afull_margin (MARGIN)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_frame_start (i_frame_start),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_ready       (o_ready),
        .i_de          (i_de),
        .o_de          (o_de),
        .o_data        (o_data),
        .o_level       (o_level),
        .o_underflow   (o_underflow),
        .o_overflow    (o_overflow)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] mdl[$];
    logic [W-1:0] sb[$];
    logic         exp_de  = 1'b0;
    logic [W-1:0] mdl_out = '0;
    logic         mdl_uf  = 1'b0;
    logic         mdl_of  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, then check after the edge.
    task automatic cycle(input logic rst, input logic fs, input logic v,
                         input logic [W-1:0] d, input logic de);
        logic         rd_ok;
        logic         wr_ok;
        logic [W-1:0] e;
        i_rst         = rst;
        i_frame_start = fs;
        i_valid       = v;
        i_data        = d;
        i_de          = de;
        if (rst || fs) begin
            mdl.delete();
            sb.delete();
            mdl_uf  = 1'b0;
            mdl_of  = 1'b0;
            exp_de  = 1'b0;
            mdl_out = '0;
        end else begin
            rd_ok  = de && (mdl.size() > 0);
            wr_ok  = v && (mdl.size() < DEPTH);
            exp_de = de;
            if (de) begin
                if (rd_ok) sb.push_back(mdl.pop_front());
                else begin
                    sb.push_back('0);
                    mdl_uf = 1'b1;
                end
            end
            if (v && !wr_ok) mdl_of = 1'b1;
            if (wr_ok) mdl.push_back(d);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        check("o_de", 32'(o_de), 32'(exp_de));
        if (exp_de) begin
            e       = sb.pop_front();
            mdl_out = e;
            check("o_data", 32'(o_data), 32'(e));
        end else begin
            check("o_data_hold", 32'(o_data), 32'(mdl_out));
        end
        check("o_level", 32'(o_level), 32'(mdl.size()));
        check("o_ready", 32'(o_ready), 32'(mdl.size() <= DEPTH - MARGIN));
        check("o_underflow", 32'(o_underflow), 32'(mdl_uf));
        check("o_overflow", 32'(o_overflow), 32'(mdl_of));
    endtask

    initial begin
        // Reset then idle
        cycle(1, 0, 0, '0, 0);
        cycle(1, 0, 0, '0, 0);
        cycle(0, 0, 0, '0, 0);

        // Ordered pass-through
        for (int i = 1; i <= 16; i++) cycle(0, 0, 1, W'(i), 0);
        for (int i = 0; i < 16; i++)  cycle(0, 0, 0, '0, 1);

        // Back-pressure, overflow, then drain (33rd word must not appear)
        cycle(0, 1, 0, '0, 0);
        for (int i = 0; i < 33; i++)  cycle(0, 0, 1, W'(24'h100 + i), 0);
        for (int i = 0; i < 33; i++)  cycle(0, 0, 0, '0, 1);

        // Underflow with concurrent write: no bypass
        cycle(0, 1, 0, '0, 0);
        cycle(0, 0, 1, 24'hABCDEF, 1);
        cycle(0, 0, 0, '0, 1);

        // Wrap-around streaming at constant level 4
        cycle(0, 1, 0, '0, 0);
        for (int i = 0; i < 4; i++)   cycle(0, 0, 1, W'(24'h1000 + i), 0);
        for (int i = 4; i < 104; i++) cycle(0, 0, 1, W'(24'h1000 + i), 1);
        for (int i = 0; i < 4; i++)   cycle(0, 0, 0, '0, 1);

        // Flush mid-stream with underflow set and a concurrent write
        cycle(0, 1, 0, '0, 0);
        cycle(0, 0, 0, '0, 1);
        for (int i = 0; i < 10; i++)  cycle(0, 0, 1, W'(24'h5A0 + i), 0);
        cycle(0, 1, 1, 24'h000777, 0);
        cycle(0, 0, 0, '0, 1);

        // Reset mid-frame discards contents
        for (int i = 0; i < 3; i++)   cycle(0, 0, 1, W'(24'h900 + i), 0);
        cycle(0, 0, 0, '0, 1);
        cycle(1, 0, 1, 24'h999, 1);
        cycle(0, 0, 0, '0, 1);
        cycle(0, 0, 1, 24'h123456, 0);
        cycle(0, 0, 0, '0, 1);
        cycle(0, 0, 0, '0, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_align_fifo.md
# pixel_align_fifo

Consuming end of the pixel latency path. Accepts pixel words that arrive with variable latency from the upstream line reader, buffers them, and releases exactly one word per cycle whenever the display timing path asserts data-enable. This re-aligns pixel data to the delayed sync/DE signals feeding the TMDS encoder. Underflow and overflow are flagged rather than hidden, so timing faults are observable per frame.

## Interface
Parameters:
- p_width, 24, pixel word width
- p_depth_log2, 5, log2 of buffer depth (32 entries)
- p_afull_margin, 4, number of free entries reserved below full before o_ready drops

Ports:
- i_clk  in  1  single clock (pixel clock)
- i_rst  in  1  reset; synchronous, active-high
- i_frame_start  in  1  single-cycle flush pulse at start of frame
- i_valid  in  1  upstream word present
- i_data  in  p_width  upstream pixel word
- o_ready  out  1  upstream may keep sending; advisory back-pressure
- i_de  in  1  display timing requests one pixel this cycle
- o_de  out  1  i_de delayed by one cycle
- o_data  out  p_width  pixel word for the request issued the previous cycle
- o_level  out  p_depth_log2+1  current occupancy
- o_underflow  out  1  sticky: a request found the buffer empty
- o_overflow  out  1  sticky: a write was dropped because the buffer was full

## Operation
- Storage: circular buffer of 2^p_depth_log2 words, with write pointer, read pointer and level counter.
- Write: accept when i_valid && level < depth. Store at wr_ptr, then increment wr_ptr (natural wrap).
- Dropped write: i_valid && level == depth drops the word and sets o_overflow. Fullness is judged on the current-cycle level, so a same-cycle read does not make room.
- Read: when i_de && level > 0, pop the word at rd_ptr, increment rd_ptr (wrap), and drive o_data next cycle.
- Read on empty: when i_de && level == 0, o_data = 0 next cycle, set o_underflow, pointers unchanged. There is no write-to-read bypass: a simultaneous write into an empty buffer does not satisfy that read.
- Level: +1 on an accepted write only, −1 on a successful read only, unchanged when both happen.
- o_ready = (level <= depth − p_afull_margin), combinational from level. Upstream may still send while o_ready is low; the margin absorbs upstream pipeline lag.
- o_data holds its last value when i_de was low the previous cycle.
- Flush: i_frame_start clears both pointers, level, both sticky flags, o_de and o_data. i_valid and i_de in that same cycle are ignored.
- Priority: i_rst > i_frame_start > normal operation.

## Timing
- Reset values (cycle after i_rst is high): o_de=0, o_data=0, o_level=0, o_underflow=0, o_overflow=0, o_ready=1.
- Read latency is 1 cycle: i_de at cycle n gives o_de/o_data at n+1.
- Earliest use of a written word: written at cycle n, requestable by i_de at n+1, appears on o_data at n+2.
- Flags set in the cycle after the offending event. They stay set until i_rst or i_frame_start.
- o_level is registered and reflects all events up to the previous edge.
- Reset mid-frame discards all contents. No partial word is emitted afterwards.

## Structure
- No shared package needed; all sizing comes from parameters.
- One sub-module: sdp_ram (simple dual-port, synchronous read, one write port and one read port, p_width × 2^p_depth_log2), so synthesis can map the buffer to block RAM.
- Control (pointers, level, flags, output register) stays in pixel_align_fifo.

## Test plan
- Reset then idle: hold i_rst 2 cycles → all outputs at reset values, o_ready=1.
- Ordered pass-through: write 0x000001..0x000010 (16 words), then i_de for 16 cycles → o_data sequence 0x000001..0x000010, each 1 cycle after its i_de. o_level returns to 0 and no flags are set.
- Back-pressure and overflow (depth 32, margin 4): write 28 words → o_ready=1. Write the 29th → o_ready=0. Continue to 32 words, then one more → o_overflow=1, o_level=32, and the 33rd word is never read out.
- Underflow: i_de with an empty buffer and a simultaneous i_valid of 0xABCDEF → o_data=0, o_underflow=1, o_level=1. The next i_de yields 0xABCDEF.
- Wrap-around: stream 100 words with i_valid and i_de both active every cycle after 4 words of prefill → output order preserved across pointer wraps, level constant at 4, no flags.
- Flush mid-stream: 10 words buffered with o_underflow set, then pulse i_frame_start together with i_valid → o_level=0, flags cleared, and the concurrent word discarded.
